switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/noc_pkg.sv | 16 +
 rtl/switch_allocator_if.sv | 15 +
 rtl/switch_allocator_rr_arbiter.sv | 28 ++
 rtl/switch_allocator.sv | 71 +++++++
 tb/tb_switch_allocator.sv | 126 ++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: port indices, default port count, output FSM state type and a one-hot encoder
package noc_pkg;
  localparam int NOC_N_PORTS = 5;
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST = 3'd4;
  typedef enum logic {IDLE, BUSY} sa_state_t;
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = v[i] ? 3'(i) : r;
    return r;
  endfunction
endpackage

// File: rtl/switch_allocator_if.sv
// switch_allocator_if: req/dest in, grant/out_sel/out_busy out; master = router buffers, slave = allocator
interface switch_allocator_if
  import noc_pkg::*;
#(
  parameter int N_PORTS = NOC_N_PORTS,
  parameter int ADDRESS_SIZE = 4
);
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0][ADDRESS_SIZE-1:0] dest;
  logic [N_PORTS-1:0] grant;
  logic [N_PORTS-1:0][2:0] out_sel;
  logic [N_PORTS-1:0] out_busy;
  modport master(output req, dest, input grant, out_sel, out_busy);
  modport slave(input req, dest, output grant, out_sel, out_busy);
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: one-hot grant from req; SA_ROUND_ROBIN_EN adds clk/rst/upd and a registered pointer moved to winner+1 on upd, else lowest index wins
module rr_arbiter #(
  parameter int N = 5
) (
`ifdef SA_ROUND_ROBIN_EN
  input  logic         clk,
  input  logic         rst,
  input  logic         upd,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
`ifdef SA_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  int w;
  always_comb begin
    gnt = '0;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req[(int'(ptr_q) + k) % N]) w = (int'(ptr_q) + k) % N;
    if (w >= 0) gnt[w] = 1'b1;
    ptr_d = upd ? 3'((w + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
`else
  assign gnt = req & (~req + N'(1));
`endif
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: XY-routed per-output IDLE/BUSY allocator; ports clk, rst, sa (slave); SA_ROUND_ROBIN_EN selects round-robin arbitration
module switch_allocator
  import noc_pkg::*;
#(
  parameter int N_PORTS = NOC_N_PORTS,
  parameter int ADDRESS_SIZE = 4,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input logic clk,
  input logic rst,
  switch_allocator_if.slave sa
);
  localparam logic [1:0] RX = 2'(ROUTER_X);
  localparam logic [1:0] RY = 2'(ROUTER_Y);
  sa_state_t state_q [N_PORTS];
  sa_state_t state_d [N_PORTS];
  logic [2:0] owner_q [N_PORTS];
  logic [2:0] owner_d [N_PORTS];
  logic [N_PORTS-1:0] grant_q, grant_d, take;
  logic [N_PORTS-1:0] elig [N_PORTS];
  logic [N_PORTS-1:0] win [N_PORTS];
  logic [2:0] route [N_PORTS];
  always_comb
    for (int i = 0; i < N_PORTS; i++)
      route[i] = sa.dest[i][1:0] > RX ? PORT_EAST :
                 sa.dest[i][1:0] < RX ? PORT_WEST :
                 sa.dest[i][3:2] > RY ? PORT_NORTH :
                 sa.dest[i][3:2] < RY ? PORT_SOUTH : PORT_LOCAL;
  // an input already holding a grant is never eligible again, so dest changes during a packet cannot cause a second grant
  always_comb
    for (int o = 0; o < N_PORTS; o++)
      for (int i = 0; i < N_PORTS; i++)
        elig[o][i] = sa.req[i] && !grant_q[i] && route[i] == 3'(o) &&
                     (route[i] == PORT_LOCAL || route[i] != 3'(i));
  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    assign take[o] = state_q[o] == IDLE && |elig[o];
    assign sa.out_busy[o] = state_q[o] == BUSY;
    assign sa.out_sel[o] = owner_q[o];
    rr_arbiter #(.N(N_PORTS)) u_arb (
`ifdef SA_ROUND_ROBIN_EN
      .clk(clk),
      .rst(rst),
      .upd(take[o]),
`endif
      .req(elig[o]),
      .gnt(win[o])
    );
  end
  // BUSY only releases on req[owner] low and cannot re-take on that edge, forcing one idle cycle
  always_comb begin
    grant_d = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      state_d[o] = take[o] || (state_q[o] == BUSY && sa.req[owner_q[o]]) ? BUSY : IDLE;
      owner_d[o] = take[o] ? onehot_to_idx(8'(win[o])) : state_d[o] == BUSY ? owner_q[o] : 3'd0;
      if (state_d[o] == BUSY) grant_d[owner_d[o]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{default: IDLE};
      owner_q <= '{default: 3'd0};
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end
  assign sa.grant = grant_q;
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vectors and corner sequences for switch_allocator at router (1,1)
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  switch_allocator_if #(.N_PORTS(5), .ADDRESS_SIZE(4)) sa ();
  switch_allocator #(.N_PORTS(5), .ADDRESS_SIZE(4), .ROUTER_X(1), .ROUTER_Y(1)) dut (
    .clk(clk),
    .rst(rst),
    .sa(sa)
  );
  localparam logic [3:0] D_L = 4'b0101;
  localparam logic [3:0] D_E = 4'b0110;
  localparam logic [3:0] D_W = 4'b0100;
  localparam logic [3:0] D_N = 4'b1001;
  localparam logic [3:0] Z = 4'b0000;
  typedef struct {
    logic [4:0]  req;
    logic [19:0] dest;
    logic [4:0]  g;
    logic [4:0]  b;
    logic [14:0] s;
  } vec_t;
  vec_t tv [10];
  int rr_exp [4];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  initial begin
    int held;
    int who;
    tv[0] = '{5'b00000, {Z, Z, Z, Z, Z}, 5'b00000, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tv[1] = '{5'b10000, {D_E, Z, Z, Z, Z}, 5'b10000, 5'b00100, {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}};
    tv[2] = '{5'b11010, {D_E, D_L, Z, D_L, Z}, 5'b10010, 5'b00101, {3'd0, 3'd0, 3'd4, 3'd0, 3'd1}};
    tv[3] = '{5'b11010, {D_E, D_L, Z, D_L, Z}, 5'b10010, 5'b00101, {3'd0, 3'd0, 3'd4, 3'd0, 3'd1}};
    tv[4] = '{5'b11000, {D_E, D_L, Z, D_L, Z}, 5'b10000, 5'b00100, {3'd0, 3'd0, 3'd4, 3'd0, 3'd0}};
    tv[5] = '{5'b11000, {D_E, D_L, Z, D_L, Z}, 5'b11000, 5'b00101, {3'd0, 3'd0, 3'd4, 3'd0, 3'd3}};
    tv[6] = '{5'b00001, {Z, Z, Z, Z, D_W}, 5'b00001, 5'b10000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tv[7] = '{5'b00101, {Z, Z, D_E, Z, D_W}, 5'b00001, 5'b10000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tv[8] = '{5'b01101, {Z, D_N, D_E, Z, D_W}, 5'b01001, 5'b10010, {3'd0, 3'd0, 3'd0, 3'd3, 3'd0}};
    tv[9] = '{5'b00000, {Z, Z, Z, Z, Z}, 5'b00000, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
`ifdef SA_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0};
`endif
    sa.req = '0;
    sa.dest = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_grant", int'(sa.grant), 0);
    chk("reset_busy", int'(sa.out_busy), 0);
    chk("reset_sel", int'(sa.out_sel), 0);
    for (int k = 0; k < 10; k++) begin
      sa.req = tv[k].req;
      sa.dest = tv[k].dest;
      step();
      chk($sformatf("vec%0d_grant", k), int'(sa.grant), int'(tv[k].g));
      chk($sformatf("vec%0d_busy", k), int'(sa.out_busy), int'(tv[k].b));
      chk($sformatf("vec%0d_sel", k), int'(sa.out_sel), int'(tv[k].s));
    end
    sa.req = 5'b10001;
    sa.dest = {D_E, Z, Z, Z, D_E};
    held = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (sa.grant == 5'b00001 && sa.out_busy == 5'b00100 && sa.out_sel[2] == 3'd0) held++;
      if (c == 10) sa.dest[0] = D_W;
    end
    chk("hold_cycles", held, 20);
    sa.req[0] = 1'b0;
    step();
    chk("release_idle_grant", int'(sa.grant), 0);
    chk("release_idle_busy", int'(sa.out_busy), 0);
    step();
    chk("waiter_grant", int'(sa.grant), 5'b10000);
    chk("waiter_sel", int'(sa.out_sel[2]), 4);
    sa.req = '0;
    step();
    step();
    sa.dest = {Z, D_E, Z, D_E, D_E};
    sa.req = 5'b01011;
    for (int n = 0; n < 4; n++) begin
      who = -1;
      for (int c = 0; c < 10 && who < 0; c++) begin
        step();
        for (int i = 0; i < 5; i++) if (sa.grant[i]) who = i;
      end
      chk($sformatf("arb_order%0d", n), who, rr_exp[n]);
      if (who >= 0) sa.req[who] = 1'b0;
      step();
      if (who >= 0) sa.req[who] = 1'b1;
    end
    sa.req = '0;
    step();
    step();
    sa.dest = {Z, Z, Z, D_L, D_E};
    sa.req = 5'b00011;
    step();
    chk("pre_reset_busy", int'(sa.out_busy), 5'b00101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_reset_grant", int'(sa.grant), 0);
    chk("mid_reset_busy", int'(sa.out_busy), 0);
    chk("mid_reset_sel", int'(sa.out_sel), 0);
    step();
    chk("rearb_grant", int'(sa.grant), 5'b00011);
    chk("rearb_busy", int'(sa.out_busy), 5'b00101);
    sa.req = '0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
